// File: rtl/bf_core_stk_if.sv
// Single program/data/io bus between the interpreter core and the arbiter side.
// bus_op encoding: 0 none, 1 read prog, 2 read data, 3 write data, 4 read io, 5 write io.
interface bf_core_stk_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] val_out;
  logic [DATA_WIDTH-1:0] val_in;
  logic [2:0]            bus_op;
  logic                  bus_ready;

  modport master (output addr, output val_out, output bus_op, input val_in, input bus_ready);
  modport slave  (input addr, input val_out, input bus_op, output val_in, output bus_ready);
endinterface

// File: rtl/bf_core_stk.sv
// Brainfuck interpreter core with hardware loop-return stack and ready-handshaked bus.
// Define BF_CURSOR_WRAP_EN to make the tape cursor wrap at both ends instead of faulting.
module bf_core_stk #(
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 12,
  parameter int STACK_DEPTH = 16,
  parameter int DATA_CELLS  = 30000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  bf_core_stk_if.master      bus,
  output logic               halted,
  output logic               error,
  output logic [2:0]         error_code
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_CELL_RD = 4'd2, S_CELL_WR = 4'd3,
                         S_IO_RD = 4'd4, S_IO_WR = 4'd5, S_LOOP = 4'd6, S_SCAN = 4'd7,
                         S_HALT = 4'd8;

  localparam logic [2:0] BUS_NONE = 3'd0, BUS_RD_PROG = 3'd1, BUS_RD_DATA = 3'd2,
                         BUS_WR_DATA = 3'd3, BUS_RD_IO = 3'd4, BUS_WR_IO = 3'd5;

  localparam logic [7:0] OP_INC = 8'h2B, OP_DEC = 8'h2D, OP_RIGHT = 8'h3E, OP_LEFT = 8'h3C,
                         OP_OUT = 8'h2E, OP_IN = 8'h2C, OP_OPEN = 8'h5B, OP_CLOSE = 8'h5D;

  localparam logic [2:0] E_STACK = 3'd1, E_CLOSE = 3'd2, E_OPEN = 3'd3, E_CURSOR = 3'd4,
                         E_DEPTH = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(DATA_CELLS - 1);
  localparam logic [SPW-1:0]        SP_FULL   = SPW'(STACK_DEPTH);

  logic [3:0]             state;
  logic [ADDR_WIDTH-1:0]  pc, cursor;
  logic [DATA_WIDTH-1:0]  acc, ir;
  logic [SPW-1:0]         sp, sp_m1;
  logic [DEPTH_WIDTH-1:0] depth;
  logic [ADDR_WIDTH-1:0]  stack [STACK_DEPTH];

  logic [2:0]            req_op;
  logic [DATA_WIDTH-1:0] wr_val;
  logic                  done;
  logic [7:0]            op, rd;
  logic                  push;

  assign op     = ir[7:0];
  assign rd     = bus.val_in[7:0];
  assign sp_m1  = sp - SPW'(1);
  assign halted = (state == S_HALT);
  assign done   = (req_op != BUS_NONE) && bus.bus_ready;
  assign push   = enable && (state == S_LOOP) && (op == OP_OPEN) && (acc != '0) && (sp != SP_FULL);

  always_comb begin
    req_op = BUS_NONE;
    case (state)
      S_FETCH, S_SCAN: req_op = BUS_RD_PROG;
      S_CELL_RD:       req_op = BUS_RD_DATA;
      S_CELL_WR:       req_op = BUS_WR_DATA;
      S_IO_RD:         req_op = BUS_RD_IO;
      S_IO_WR:         req_op = BUS_WR_IO;
      default:         req_op = BUS_NONE;
    endcase
    if (!enable || reset) req_op = BUS_NONE;
  end

  always_comb begin
    wr_val = acc;
    if (op == OP_INC)      wr_val = acc + DATA_WIDTH'(1);
    else if (op == OP_DEC) wr_val = acc - DATA_WIDTH'(1);
  end

  always_comb begin
    bus.bus_op  = req_op;
    bus.addr    = '0;
    bus.val_out = '0;
    case (req_op)
      BUS_RD_PROG:              bus.addr = pc;
      BUS_RD_DATA, BUS_WR_DATA: bus.addr = cursor;
      default:                  bus.addr = '0;
    endcase
    if (req_op == BUS_WR_DATA)    bus.val_out = wr_val;
    else if (req_op == BUS_WR_IO) bus.val_out = acc;
  end

  // Return addresses carry no reset; sp alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push) stack[sp[IW-1:0]] <= pc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= '0;
      cursor     <= '0;
      acc        <= '0;
      ir         <= '0;
      sp         <= '0;
      depth      <= '0;
      error      <= 1'b0;
      error_code <= 3'd0;
    end else if (enable) begin
      case (state)
        S_FETCH: if (done) begin
          ir    <= bus.val_in;
          pc    <= pc + ADDR_WIDTH'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_FETCH;
          case (op)
            OP_INC, OP_DEC, OP_OUT, OP_OPEN, OP_CLOSE: state <= S_CELL_RD;
            OP_IN: state <= S_IO_RD;
            8'h00: state <= S_HALT;
            OP_RIGHT:
              if (cursor == LAST_CELL) begin
`ifdef BF_CURSOR_WRAP_EN
                cursor <= '0;
`else
                state <= S_HALT; error <= 1'b1; error_code <= E_CURSOR;
`endif
              end else cursor <= cursor + ADDR_WIDTH'(1);
            OP_LEFT:
              if (cursor == '0) begin
`ifdef BF_CURSOR_WRAP_EN
                cursor <= LAST_CELL;
`else
                state <= S_HALT; error <= 1'b1; error_code <= E_CURSOR;
`endif
              end else cursor <= cursor - ADDR_WIDTH'(1);
            default: state <= S_FETCH;
          endcase
        end
        S_CELL_RD: if (done) begin
          acc <= bus.val_in;
          if (op == OP_INC || op == OP_DEC) state <= S_CELL_WR;
          else if (op == OP_OUT)            state <= S_IO_WR;
          else                              state <= S_LOOP;
        end
        S_CELL_WR: if (done) state <= S_FETCH;
        S_IO_RD: if (done) begin
          acc   <= bus.val_in;
          state <= S_CELL_WR;
        end
        S_IO_WR: if (done) state <= S_FETCH;
        S_LOOP:
          if (op == OP_OPEN) begin
            if (acc == '0) begin
              depth <= '0;
              state <= S_SCAN;
            end else if (sp == SP_FULL) begin
              state <= S_HALT; error <= 1'b1; error_code <= E_STACK;
            end else begin
              sp    <= sp + SPW'(1);
              state <= S_FETCH;
            end
          end else if (sp == '0) begin
            state <= S_HALT; error <= 1'b1; error_code <= E_CLOSE;
          end else begin
            if (acc != '0) pc <= stack[sp_m1[IW-1:0]];
            else           sp <= sp_m1;
            state <= S_FETCH;
          end
        S_SCAN: if (done) begin
          pc <= pc + ADDR_WIDTH'(1);
          case (rd)
            OP_OPEN:
              if (depth == '1) begin
                state <= S_HALT; error <= 1'b1; error_code <= E_DEPTH;
              end else depth <= depth + DEPTH_WIDTH'(1);
            OP_CLOSE:
              if (depth == '0) state <= S_FETCH;
              else             depth <= depth - DEPTH_WIDTH'(1);
            8'h00: begin
              state <= S_HALT; error <= 1'b1; error_code <= E_OPEN;
            end
            default: state <= S_SCAN;
          endcase
        end
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_bf_core_stk.sv
// Directed bench for bf_core_stk: behavioural program/data RAM and io port on the shared bus.
module tb_bf_core_stk;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       halted, error;
  logic [2:0] error_code;

  logic       stall_mode = 1'b0;
  logic [7:0] io_in = 8'h00;
  logic [7:0] cell0_init = 8'h00;

  logic [7:0] prog [8192];
  logic [7:0] data [32768];
  int         wait_cnt;
  int         fetch_cnt, wr_cnt, io_cnt, stable_viol;
  logic [7:0] io_last;
  logic [14:0] last_wr_addr;
  int         fetch_log[$];

  logic        prev_pend;
  logic [2:0]  prev_op;
  logic [14:0] prev_addr;
  logic [7:0]  prev_val;

  int passed = 0;
  int total  = 0;

  bf_core_stk_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) bus ();

  bf_core_stk dut (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus),
    .halted(halted), .error(error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  assign bus.bus_ready = stall_mode ? (wait_cnt == 3) : 1'b1;
  assign bus.val_in = (bus.bus_op == 3'd1) ? prog[bus.addr[12:0]] :
                      (bus.bus_op == 3'd2) ? data[bus.addr] :
                      (bus.bus_op == 3'd4) ? io_in : 8'h00;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32768; i++) data[i] = 8'h00;
      data[0] = cell0_init;
      fetch_cnt = 0; wr_cnt = 0; io_cnt = 0; io_last = 8'h00; last_wr_addr = '0;
      fetch_log.delete();
      wait_cnt = 0;
    end else begin
      if (enable && bus.bus_ready) begin
        case (bus.bus_op)
          3'd1: begin fetch_cnt++; fetch_log.push_back(int'(bus.addr)); end
          3'd3: begin data[bus.addr] = bus.val_out; wr_cnt++; last_wr_addr = bus.addr; end
          3'd5: begin io_cnt++; io_last = bus.val_out; end
          default: ;
        endcase
      end
      if (bus.bus_op != 3'd0 && !bus.bus_ready) wait_cnt = wait_cnt + 1;
      else wait_cnt = 0;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      stable_viol = 0;
      prev_pend = 1'b0;
    end else begin
      if (prev_pend && (bus.bus_op !== prev_op || bus.addr !== prev_addr || bus.val_out !== prev_val))
        stable_viol++;
      prev_pend = (bus.bus_op != 3'd0) && !bus.bus_ready;
      prev_op = bus.bus_op; prev_addr = bus.addr; prev_val = bus.val_out;
    end
  end

  task automatic load(input string s);
    for (int i = 0; i < 8192; i++) prog[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) prog[i] = s[i];
  endtask

  task automatic start(input logic [7:0] c0);
    cell0_init = c0;
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    total++;
    if (!halted) $display("FAIL timeout: halted=%0b after %0d cycles, required 1", halted, cyc);
    else passed++;
  endtask

  task automatic test_reset;
    load("+");
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    total++; if (bus.bus_op !== 3'd0 || halted !== 1'b0 || error !== 1'b0 || error_code !== 3'd0 || bus.addr !== 15'd0)
      $display("FAIL reset_outputs: op=%0d halted=%0b err=%0b code=%0d addr=%0d, required 0/0/0/0/0",
               bus.bus_op, halted, error, error_code, bus.addr);
    else passed++;
    reset = 1'b0;
    #1;
    total++; if (bus.bus_op !== 3'd1 || bus.addr !== 15'd0)
      $display("FAIL reset_first_fetch: op=%0d addr=%0d, required 1 @0", bus.bus_op, bus.addr);
    else passed++;
  endtask

  task automatic test_output;
    int cyc;
    load("+++.");
    start(8'h00);
    run(200, cyc);
    total++; if (io_cnt !== 1 || io_last !== 8'h03)
      $display("FAIL out_value: count=%0d val=%0h, required 1 / 03", io_cnt, io_last);
    else passed++;
    total++; if (error !== 1'b0 || error_code !== 3'd0)
      $display("FAIL out_clean: err=%0b code=%0d, required 0/0", error, error_code);
    else passed++;
  endtask

  task automatic test_latency;
    int cyc;
    load(">>+");
    start(8'h00);
    run(200, cyc);
    total++; if (cyc !== 10)
      $display("FAIL latency_move_inc: cycles=%0d, required 10", cyc);
    else passed++;
    total++; if (data[2] !== 8'h01 || last_wr_addr !== 15'd2)
      $display("FAIL latency_cell: cell2=%0h addr=%0d, required 01 @2", data[2], last_wr_addr);
    else passed++;
  endtask

  task automatic test_loop;
    int cyc;
    load("++[->+<]>.");
    start(8'h00);
    run(500, cyc);
    total++; if (io_last !== 8'h02 || io_cnt !== 1)
      $display("FAIL loop_out: val=%0h count=%0d, required 02 / 1", io_last, io_cnt);
    else passed++;
    total++; if (fetch_cnt !== 16)
      $display("FAIL loop_fetches: count=%0d, required 16", fetch_cnt);
    else passed++;
    total++; if (fetch_log.size() < 9 || fetch_log[8] !== 3)
      $display("FAIL loop_jump_target: fetch[8]=%0d, required 3", (fetch_log.size() > 8) ? fetch_log[8] : -1);
    else passed++;
    total++; if (cyc !== 52)
      $display("FAIL loop_cycles: cycles=%0d, required 52", cyc);
    else passed++;
  endtask

  task automatic test_scan;
    int cyc;
    load("[[[]]+].");
    start(8'h00);
    run(200, cyc);
    total++; if (wr_cnt !== 0 || data[0] !== 8'h00)
      $display("FAIL scan_skip: writes=%0d cell0=%0h, required 0 / 00", wr_cnt, data[0]);
    else passed++;
    total++; if (cyc !== 16 || error !== 1'b0 || io_cnt !== 1)
      $display("FAIL scan_path: cycles=%0d err=%0b io=%0d, required 16/0/1", cyc, error, io_cnt);
    else passed++;
  endtask

  task automatic test_errors;
    int cyc;
    load("[[[[[[[[[[[[[[[[[[");
    start(8'h01);
    run(500, cyc);
    total++; if (error !== 1'b1 || error_code !== 3'd1 || fetch_cnt !== 17)
      $display("FAIL stack_overflow: err=%0b code=%0d fetches=%0d, required 1/1/17", error, error_code, fetch_cnt);
    else passed++;
    load("]");
    start(8'h01);
    run(100, cyc);
    total++; if (error !== 1'b1 || error_code !== 3'd2)
      $display("FAIL unmatched_close: err=%0b code=%0d, required 1/2", error, error_code);
    else passed++;
    load("[");
    start(8'h00);
    run(100, cyc);
    total++; if (error !== 1'b1 || error_code !== 3'd3)
      $display("FAIL unmatched_open: err=%0b code=%0d, required 1/3", error, error_code);
    else passed++;
    load("");
    for (int i = 0; i <= 4096; i++) prog[i] = 8'h5B;
    start(8'h00);
    run(6000, cyc);
    total++; if (error !== 1'b1 || error_code !== 3'd5 || fetch_cnt !== 4097)
      $display("FAIL depth_overflow: err=%0b code=%0d fetches=%0d, required 1/5/4097", error, error_code, fetch_cnt);
    else passed++;
  endtask

  task automatic test_stall;
    int cyc;
    load("-.");
    stall_mode = 1'b1;
    start(8'h00);
    run(300, cyc);
    stall_mode = 1'b0;
    total++; if (io_last !== 8'hFF || data[0] !== 8'hFF)
      $display("FAIL stall_value: io=%0h cell0=%0h, required ff / ff", io_last, data[0]);
    else passed++;
    total++; if (stable_viol !== 0)
      $display("FAIL stall_stable: changes=%0d, required 0", stable_viol);
    else passed++;
    total++; if (cyc !== 31)
      $display("FAIL stall_cycles: cycles=%0d, required 31", cyc);
    else passed++;
  endtask

  task automatic test_enable_io;
    int cyc;
    int none_bad;
    load(",.");
    io_in = 8'h5A;
    start(8'h00);
    enable = 1'b0;
    none_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus.bus_op !== 3'd0) none_bad++;
    end
    total++; if (none_bad !== 0 || fetch_cnt !== 0)
      $display("FAIL enable_freeze: busy_cycles=%0d fetches=%0d, required 0/0", none_bad, fetch_cnt);
    else passed++;
    enable = 1'b1;
    #1;
    total++; if (bus.bus_op !== 3'd1 || bus.addr !== 15'd0)
      $display("FAIL enable_reissue: op=%0d addr=%0d, required 1 @0", bus.bus_op, bus.addr);
    else passed++;
    run(200, cyc);
    total++; if (io_last !== 8'h5A || data[0] !== 8'h5A)
      $display("FAIL io_passthrough: io=%0h cell0=%0h, required 5a / 5a", io_last, data[0]);
    else passed++;
  endtask

  task automatic test_cursor;
    int cyc;
`ifdef BF_CURSOR_WRAP_EN
    load("<+");
    start(8'h00);
    run(200, cyc);
    total++; if (error !== 1'b0 || last_wr_addr !== 15'd29999 || data[29999] !== 8'h01)
      $display("FAIL cursor_wrap: err=%0b addr=%0d cell=%0h, required 0 @29999 01", error, last_wr_addr, data[29999]);
    else passed++;
`else
    load("<+");
    start(8'h00);
    run(200, cyc);
    total++; if (error !== 1'b1 || error_code !== 3'd4 || wr_cnt !== 0)
      $display("FAIL cursor_fault: err=%0b code=%0d writes=%0d, required 1/4/0", error, error_code, wr_cnt);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_scan;
    string s;
    s = "[";
    for (int i = 0; i < 20; i++) s = {s, "+"};
    s = {s, "]"};
    load(s);
    start(8'h00);
    for (int i = 0; i < 8; i++) @(negedge clock);
    total++; if (bus.bus_op !== 3'd1 || bus.addr !== 15'd5)
      $display("FAIL scan_progress: op=%0d addr=%0d, required 1 @5", bus.bus_op, bus.addr);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.bus_op !== 3'd0)
      $display("FAIL async_reset: op=%0d, required 0", bus.bus_op);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (bus.bus_op !== 3'd1 || bus.addr !== 15'd0)
      $display("FAIL reset_refetch: op=%0d addr=%0d, required 1 @0", bus.bus_op, bus.addr);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_output;
    test_latency;
    test_loop;
    test_scan;
    test_errors;
    test_stall;
    test_enable_io;
    test_cursor;
    test_reset_mid_scan;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
